// File: rtl/hazard_pkg.sv
// Shared types and stall-length constants for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        FLUSH  = 2'd2,
        MWAIT  = 2'd3
    } hz_state_t;

    localparam logic [1:0] STALL_LOAD_USE  = 2'd1;
    localparam logic [1:0] STALL_EX_NOFWD  = 2'd2;
    localparam logic [1:0] STALL_MEM_NOFWD = 2'd1;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_read_reg1;
    logic [REG_W-1:0] id_read_reg2;
    logic             id_uses_reg1;
    logic             id_uses_reg2;
    logic [REG_W-1:0] ex_write_reg;
    logic             ex_rf_write;
    logic             ex_memtoreg;
    logic [REG_W-1:0] mem_write_reg;
    logic             mem_rf_write;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_wen;
    logic             ifid_wen;
    logic             idex_wen;
    logic             exmem_wen;
    logic             ifid_flush;
    logic             idex_bubble;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_read_reg1, id_read_reg2, id_uses_reg1, id_uses_reg2,
        output ex_write_reg, ex_rf_write, ex_memtoreg,
        output mem_write_reg, mem_rf_write, branch_taken, mem_busy,
        input  pc_wen, ifid_wen, idex_wen, exmem_wen,
        input  ifid_flush, idex_bubble, stall_count
    );

    modport slave (
        input  id_read_reg1, id_read_reg2, id_uses_reg1, id_uses_reg2,
        input  ex_write_reg, ex_rf_write, ex_memtoreg,
        input  mem_write_reg, mem_rf_write, branch_taken, mem_busy,
        output pc_wen, ifid_wen, idex_wen, exmem_wen,
        output ifid_flush, idex_bubble, stall_count
    );
endinterface

// File: rtl/hazard_match.sv
// Compares one producer destination against both decode sources; r0 never matches.
module hazard_match #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] prod_reg_i,
    input  logic             prod_wr_i,
    input  logic [REG_W-1:0] src1_i,
    input  logic             use1_i,
    input  logic [REG_W-1:0] src2_i,
    input  logic             use2_i,
    output logic             match_o
);
    logic live_s;

    assign live_s  = prod_wr_i && (prod_reg_i != {REG_W{1'b0}});
    assign match_o = live_s && ((use1_i && (src1_i == prod_reg_i)) ||
                                (use2_i && (src2_i == prod_reg_i)));
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: data-hazard stalls, branch flushes, memory waits.
// Define HAZARD_FORWARD_EN when the EX/MEM->EX forwarding network is present.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);
    hz_state_t        state_q, state_d, ret_q, ret_d, eff_s;
    logic [1:0]       scnt_q, scnt_d, need_s;
    logic [CNT_W-1:0] stall_count_q;
    logic             ex_match_s, mem_match_s;
    logic             pc_wen_s, ifid_wen_s, idex_wen_s, exmem_wen_s;
    logic             flush_s, bubble_s;

    hazard_match #(.REG_W(REG_W)) u_ex_match (
        .prod_reg_i (hz.ex_write_reg),
        .prod_wr_i  (hz.ex_rf_write),
        .src1_i     (hz.id_read_reg1),
        .use1_i     (hz.id_uses_reg1),
        .src2_i     (hz.id_read_reg2),
        .use2_i     (hz.id_uses_reg2),
        .match_o    (ex_match_s)
    );

    hazard_match #(.REG_W(REG_W)) u_mem_match (
        .prod_reg_i (hz.mem_write_reg),
        .prod_wr_i  (hz.mem_rf_write),
        .src1_i     (hz.id_read_reg1),
        .use1_i     (hz.id_uses_reg1),
        .src2_i     (hz.id_read_reg2),
        .use2_i     (hz.id_uses_reg2),
        .match_o    (mem_match_s)
    );

`ifdef HAZARD_FORWARD_EN
    logic unused_mem_match_s;
    assign unused_mem_match_s = mem_match_s;
    assign need_s = (ex_match_s && hz.ex_memtoreg) ? STALL_LOAD_USE : 2'd0;
`else
    logic unused_memtoreg_s;
    assign unused_memtoreg_s = hz.ex_memtoreg;
    assign need_s = ex_match_s  ? STALL_EX_NOFWD :
                    mem_match_s ? STALL_MEM_NOFWD : 2'd0;
`endif

    // Next-state and Mealy outputs; MWAIT resumes as whatever state it interrupted.
    always_comb begin
        state_d     = state_q;
        ret_d       = ret_q;
        scnt_d      = scnt_q;
        pc_wen_s    = 1'b1;
        ifid_wen_s  = 1'b1;
        idex_wen_s  = 1'b1;
        exmem_wen_s = 1'b1;
        flush_s     = 1'b0;
        bubble_s    = 1'b0;
        eff_s       = (state_q == MWAIT) ? ret_q : state_q;

        if (hz.mem_busy) begin
            pc_wen_s    = 1'b0;
            ifid_wen_s  = 1'b0;
            idex_wen_s  = 1'b0;
            exmem_wen_s = 1'b0;
            state_d     = MWAIT;
            if (state_q != MWAIT) begin
                ret_d = state_q;
            end else begin
                ret_d = ret_q;
            end
        end else if (hz.branch_taken) begin
            flush_s  = 1'b1;
            bubble_s = 1'b1;
            state_d  = FLUSH;
            scnt_d   = 2'd0;
        end else begin
            case (eff_s)
                RUN: begin
                    if (need_s != 2'd0) begin
                        pc_wen_s   = 1'b0;
                        ifid_wen_s = 1'b0;
                        bubble_s   = 1'b1;
                        scnt_d     = need_s - 2'd1;
                        state_d    = (need_s > 2'd1) ? DSTALL : RUN;
                    end else begin
                        state_d = RUN;
                    end
                end
                DSTALL: begin
                    pc_wen_s   = 1'b0;
                    ifid_wen_s = 1'b0;
                    bubble_s   = 1'b1;
                    if (scnt_q > 2'd1) begin
                        scnt_d  = scnt_q - 2'd1;
                        state_d = DSTALL;
                    end else begin
                        scnt_d  = 2'd0;
                        state_d = RUN;
                    end
                end
                FLUSH:   state_d = RUN;
                default: state_d = RUN;
            endcase
        end

        if (rst) begin
            pc_wen_s    = 1'b0;
            ifid_wen_s  = 1'b0;
            idex_wen_s  = 1'b0;
            exmem_wen_s = 1'b0;
            flush_s     = 1'b0;
            bubble_s    = 1'b0;
        end else begin
            flush_s = flush_s;
        end
    end

    // FSM state, resume state and stall down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            ret_q   <= RUN;
            scnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            scnt_q  <= scnt_d;
        end
    end

    // Saturating count of cycles with the PC held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count_q <= {CNT_W{1'b0}};
        end else if (!pc_wen_s && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_q <= stall_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_count_q <= stall_count_q;
        end
    end

    assign hz.pc_wen      = pc_wen_s;
    assign hz.ifid_wen    = ifid_wen_s;
    assign hz.idex_wen    = idex_wen_s;
    assign hz.exmem_wen   = exmem_wen_s;
    assign hz.ifid_flush  = flush_s;
    assign hz.idex_bubble = bubble_s;
    assign hz.stall_count = stall_count_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (no-forwarding build, CNT_W=4 for saturation).
module tb_hazard_ctrl;
    localparam int REG_W = 4;
    localparam int CNT_W = 4;

    // {pc_wen, ifid_wen, idex_wen, exmem_wen, ifid_flush, idex_bubble}
    localparam logic [5:0] RUNOK  = 6'b111100;
    localparam logic [5:0] STALL  = 6'b001101;
    localparam logic [5:0] BUSY   = 6'b000000;
    localparam logic [5:0] BRANCH = 6'b111111;
    localparam logic [5:0] RSTV   = 6'b000000;

    typedef struct packed {
        logic [3:0] r1;
        logic       u1;
        logic [3:0] r2;
        logic       u2;
        logic [3:0] exr;
        logic       exw;
        logic       exm;
        logic [3:0] memr;
        logic       memw;
        logic       br;
        logic       busy;
        logic       rst;
    } vec_t;

    typedef struct {
        logic [5:0]       ctl;
        logic [CNT_W-1:0] cnt;
        string            name;
    } exp_t;

    logic clk;
    logic rst;
    exp_t sb_q[$];
    logic [CNT_W-1:0] model_cnt;
    int n_checks;
    int n_pass;

    hazard_ctrl_if #(.REG_W(REG_W), .CNT_W(CNT_W)) hz_if ();

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t idle();
        vec_t v;
        v = '0;
        return v;
    endfunction

    function automatic vec_t ex_hz(input logic [3:0] r);
        vec_t v;
        v     = '0;
        v.r1  = r;
        v.u1  = 1'b1;
        v.exr = r;
        v.exw = 1'b1;
        return v;
    endfunction

    function automatic vec_t mem_hz(input logic [3:0] r);
        vec_t v;
        v      = '0;
        v.r2   = r;
        v.u2   = 1'b1;
        v.memr = r;
        v.memw = 1'b1;
        return v;
    endfunction

    task automatic step(input vec_t v, input logic [5:0] ctl, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        hz_if.id_read_reg1  = v.r1;
        hz_if.id_uses_reg1  = v.u1;
        hz_if.id_read_reg2  = v.r2;
        hz_if.id_uses_reg2  = v.u2;
        hz_if.ex_write_reg  = v.exr;
        hz_if.ex_rf_write   = v.exw;
        hz_if.ex_memtoreg   = v.exm;
        hz_if.mem_write_reg = v.memr;
        hz_if.mem_rf_write  = v.memw;
        hz_if.branch_taken  = v.br;
        hz_if.mem_busy      = v.busy;
        rst                 = v.rst;
        if (v.rst) model_cnt = '0;
        e.ctl  = ctl;
        e.cnt  = model_cnt;
        e.name = name;
        sb_q.push_back(e);
        if (!v.rst && !ctl[5] && (model_cnt != {CNT_W{1'b1}})) model_cnt = model_cnt + 4'd1;
    endtask

    // Monitor: outputs are live every cycle, so compare one queued entry per negedge.
    initial begin : monitor
        exp_t       e;
        logic [5:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {hz_if.pc_wen, hz_if.ifid_wen, hz_if.idex_wen,
                       hz_if.exmem_wen, hz_if.ifid_flush, hz_if.idex_bubble};
                n_checks++;
                if (act === e.ctl) n_pass++;
                else $display("FAIL %s ctl: got %b want %b", e.name, act, e.ctl);
                n_checks++;
                if (hz_if.stall_count === e.cnt) n_pass++;
                else $display("FAIL %s stall_count: got %0d want %0d", e.name, hz_if.stall_count, e.cnt);
            end
        end
    end

    initial begin : stim
        vec_t v;
        n_checks  = 0;
        n_pass    = 0;
        model_cnt = '0;
        rst       = 1'b1;
        hz_if.id_read_reg1 = '0; hz_if.id_uses_reg1 = 1'b0;
        hz_if.id_read_reg2 = '0; hz_if.id_uses_reg2 = 1'b0;
        hz_if.ex_write_reg = '0; hz_if.ex_rf_write = 1'b0; hz_if.ex_memtoreg = 1'b0;
        hz_if.mem_write_reg = '0; hz_if.mem_rf_write = 1'b0;
        hz_if.branch_taken = 1'b0; hz_if.mem_busy = 1'b0;

        // Reset held with a hazard present
        for (int i = 0; i < 3; i++) begin
            v = ex_hz(4'd5); v.rst = 1'b1;
            step(v, RSTV, "reset_hold");
        end
        step(idle(), RUNOK, "reset_release");

        // EX match without forwarding: two stall cycles
        step(ex_hz(4'd5),  STALL, "ex_r5_c1");
        step(mem_hz(4'd5), STALL, "ex_r5_c2");
        step(idle(),       RUNOK, "ex_r5_done");

        // MEM-only match: one stall cycle
        step(mem_hz(4'd5), STALL, "mem_r5_c1");
        step(idle(),       RUNOK, "mem_r5_done");

        // Non-hazards: r0, source unused, producer not writing
        step(ex_hz(4'd0),  RUNOK, "ex_r0");
        step(mem_hz(4'd0), RUNOK, "mem_r0");
        v = ex_hz(4'd5); v.u1 = 1'b0;
        step(v, RUNOK, "unused_src");
        v = ex_hz(4'd5); v.exw = 1'b0;
        step(v, RUNOK, "no_rf_write");

        // Branch beats hazard; FLUSH ignores the wrong-path hazard
        v = ex_hz(4'd5); v.br = 1'b1;
        step(v, BRANCH, "branch_over_hz");
        step(ex_hz(4'd5), RUNOK, "flush_cycle");
        step(idle(), RUNOK, "after_flush");

        // mem_busy four cycles inside a DSTALL
        step(ex_hz(4'd5), STALL, "busy_ds_start");
        for (int i = 0; i < 4; i++) begin
            v = ex_hz(4'd5); v.busy = 1'b1;
            step(v, BUSY, "busy_ds_wait");
        end
        step(ex_hz(4'd5), STALL, "busy_ds_resume");
        step(idle(), RUNOK, "busy_ds_done");

        // Busy together with branch: branch deferred until not busy
        v = idle(); v.busy = 1'b1; v.br = 1'b1;
        step(v, BUSY, "busy_branch");
        v = idle(); v.br = 1'b1;
        step(v, BRANCH, "branch_after_busy");
        step(idle(), RUNOK, "branch_flush");
        step(idle(), RUNOK, "branch_run");

        // Counter saturation
        for (int i = 0; i < 6; i++) begin
            step(mem_hz(4'd7), STALL, "sat_stall");
            step(idle(), RUNOK, "sat_idle");
        end
        step(idle(), RUNOK, "sat_hold");

        // Reset mid-DSTALL leaves no residual stall
        step(ex_hz(4'd5), STALL, "rst_ds_start");
        v = ex_hz(4'd5); v.rst = 1'b1;
        step(v, RSTV, "rst_ds_abort");
        step(idle(), RUNOK, "rst_ds_clean");

        // Reset mid-MWAIT
        v = idle(); v.busy = 1'b1;
        step(v, BUSY, "rst_mw_busy");
        v = idle(); v.busy = 1'b1; v.rst = 1'b1;
        step(v, RSTV, "rst_mw_abort");
        step(idle(), RUNOK, "rst_mw_clean");

        @(negedge clk);
        #1;
        n_checks++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain: got %0d left want 0", sb_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 16-bit five-stage core. It sits beside the ID/EX pipeline register and is the other end of that register's `wen`/`stall`/`flush` control interface. It compares the decode-stage source registers against destinations held in ID/EX and EX/MEM, then drives the write enables and bubble/flush controls for PC, IF/ID, ID/EX and EX/MEM. It also handles taken-branch flushes, multi-cycle data-memory waits, and a saturating stall-cycle performance counter.

## Interface
Parameters:
- `REG_W`, default 4: register-index width.
- `CNT_W`, default 16: stall counter width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `id_read_reg1`, `id_read_reg2`  in  REG_W  decode-stage source register indices.
- `id_uses_reg1`, `id_uses_reg2`  in  1  decode instruction actually reads that source.
- `ex_write_reg`  in  REG_W  destination register held in ID/EX (EX stage).
- `ex_rf_write`, `ex_memtoreg`  in  1  EX-stage register write and load flags.
- `mem_write_reg`  in  REG_W  destination register held in EX/MEM.
- `mem_rf_write`  in  1  MEM-stage register write flag.
- `branch_taken`  in  1  branch resolved taken in EX this cycle.
- `mem_busy`  in  1  data memory not ready; MEM stage must hold.
- `pc_wen`, `ifid_wen`, `idex_wen`, `exmem_wen`  out  1  pipeline register write enables.
- `ifid_flush`  out  1  load NOP into IF/ID.
- `idex_bubble`  out  1  load bubble into ID/EX: `rf_write`=0, `dm_write`=0, `branch`=0, `flush_d`=1.
- `stall_count`  out  CNT_W  cycles with `pc_wen`=0 since reset; saturates at all-ones.

## Operation
- States: RUN, DSTALL, FLUSH, MWAIT. A down-counter `scnt` (2 bits) is used in DSTALL.
- Outputs are Mealy: combinational from state and current inputs, with zero-cycle latency.
- Register 0 is hardwired zero and never creates a hazard.
- A match on a source means: `id_uses_regN` is set, the index equals the producer's destination, the producer's write flag is set, and the destination is non-zero.
- Priority in every state, highest first: `mem_busy`, then `branch_taken`, then data hazard.
- `mem_busy`=1:
  - All four wens are 0, and flush and bubble are 0.
  - Next state is MWAIT. `scnt` holds its value.
  - When `mem_busy` falls, return to the state held before MWAIT.
- `branch_taken`=1, not busy:
  - `ifid_flush`=1 and `idex_bubble`=1.
  - `pc_wen`, `ifid_wen`, `idex_wen` and `exmem_wen` are all 1.
  - Next state is FLUSH; any pending DSTALL is cancelled and `scnt` is cleared to 0.
- FLUSH: lasts exactly one cycle and ignores data hazards because the decode instruction is wrong-path. All wens are 1, then the FSM returns to RUN.
- RUN with a data hazard:
  - `pc_wen`=0, `ifid_wen`=0, `idex_bubble`=1; `idex_wen`=1 and `exmem_wen`=1.
  - `scnt` is loaded with the required count minus 1; go to DSTALL if that value is non-zero, otherwise stay in RUN.
- DSTALL: applies the same outputs as a RUN data hazard. `scnt` decrements each cycle; at 0 the FSM returns to RUN and re-evaluates hazards.
- Stall counts:
  - FORWARD_EN: an EX load-use match needs 1 cycle.
  - No FORWARD_EN: an EX match needs 2 cycles and a MEM-only match needs 1 cycle. The maximum wins.
- `stall_count` increments on every cycle where `pc_wen`=0, except during reset, and saturates.

## Timing
- Reset (`rst`=1, asynchronous):
  - State RUN, `scnt`=0, `stall_count`=0.
  - All wens, `ifid_flush` and `idex_bubble` are forced to 0 while `rst` is high.
- The first cycle after reset deassertion behaves as RUN.
- A hazard detected in cycle N bubbles ID/EX at edge N+1. The stalled instruction leaves ID at the edge after the last stall cycle.
- Simultaneous `branch_taken` and hazard: the branch wins, with no stall cycle.
- Simultaneous `mem_busy` and `branch_taken`: the branch is held and is taken on the first non-busy cycle, because the EX inputs are frozen.
- `rst` asserted mid-DSTALL or mid-MWAIT aborts immediately; no residual stall remains.

## Configuration
- `HAZARD_FORWARD_EN` defined:
  - An EX/MEM→EX forwarding network exists.
  - Only EX-stage load-use stalls, for 1 cycle.
  - `mem_write_reg` and `mem_rf_write` are ignored.
- `HAZARD_FORWARD_EN` undefined:
  - There is no forwarding.
  - An EX match stalls 2 cycles and a MEM-only match stalls 1 cycle.
  - This relies on the register file's write-before-read bypass in WB.

## Structure
- `hazard_pkg` holds:
  - the state enum `hz_state_t` (RUN, DSTALL, FLUSH, MWAIT);
  - the constants `STALL_LOAD_USE`=1, `STALL_EX_NOFWD`=2, `STALL_MEM_NOFWD`=1.
- One sub-module, `hazard_match`: a combinational comparator taking one producer (index, write flag) and both decode sources (index, use flag), outputting a match bit. It is instantiated once for EX and once for MEM.

## Test plan
- Reset: hold `rst` 3 cycles with a hazard present → all wens 0, flush/bubble 0, `stall_count`=0. Release → wens 1 next cycle.
- Load-use (FORWARD_EN): EX holds `ex_write_reg`=3, `ex_memtoreg`=1, `ex_rf_write`=1; decode reads r3 → exactly 1 cycle of `pc_wen`=0 and `idex_bubble`=1, and `stall_count`=1.
- No-forward: EX writes r5 and decode reads r5 → 2 stall cycles. MEM-only write to r5 → 1 cycle. A write to r0 → 0 cycles.
- Branch over hazard: `branch_taken`=1 while a load-use matches → `ifid_flush`=1 and `idex_bubble`=1 with all wens 1 for 1 cycle, with no stall, then RUN.
- mem_busy for 4 cycles in the middle of a DSTALL → all wens 0 for 4 cycles, then the remaining DSTALL cycle completes and `stall_count` rises by 5 total.
- Saturation: preload by forcing 65534 stalls (or use CNT_W=4 for 14 stalls), then 3 more stall cycles → `stall_count` holds at all-ones.
